// File: rtl/ddr_pkg.sv
// ddr_pkg
//   Shared DDR definitions for the bank scheduler slice.
//   - 5-bit bank FSM state codes (as reported on bank_state)
//   - scheduler state enum and precharge return-target enum
package ddr_pkg;

    // Bank FSM state encoding. Only the codes the scheduler acts on are
    // named here; any other value is treated as "not there yet" and the
    // scheduler holds its current command.
    localparam logic [4:0] BS_IDLE        = 5'd0;
    localparam logic [4:0] BS_ACTIVATING  = 5'd1;
    localparam logic [4:0] BS_BANK_ACTIVE = 5'd3;
    localparam logic [4:0] BS_PRECHARGING = 5'd10;
    localparam logic [4:0] BS_READING     = 5'd11;
    localparam logic [4:0] BS_REFRESHING  = 5'd13;
    localparam logic [4:0] BS_WRITING     = 5'd18;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_PRE_WAIT,
        S_ACT,
        S_ACT_WAIT,
        S_RW,
        S_BST,
        S_REF,
        S_REF_WAIT
    } sched_state_e;

    // Where a precharge sequence continues once the bank is back to Idle.
    typedef enum logic {
        RET_ACT,
        RET_REF
    } ret_e;

endpackage

// File: rtl/refresh_timer.sv
// refresh_timer
//   Free-running down counter that flags each refresh interval.
//   Ports:
//     clk, rst_n  clock, async active-low reset (counter loads T_REFI)
//     expire      high for the one cycle the counter sits at 1; the
//                 counter reloads T_REFI on the following edge
module refresh_timer #(
    parameter int T_REFI = 7800,
    parameter int REFI_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic expire
);

    logic [REFI_W-1:0] cnt;

    assign expire = (cnt == REFI_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= REFI_W'(T_REFI);
        else if (expire) cnt <= REFI_W'(T_REFI);
        else             cnt <= cnt - REFI_W'(1);
    end

endmodule

// File: rtl/bank_cmd_scheduler.sv
// bank_cmd_scheduler
//   Drives one DDR bank FSM with level commands under an open-row policy
//   and inserts periodic refresh.
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     req_valid/req_ready        request handshake; req_we, req_row latched
//     bank_state                 bank FSM state (ddr_pkg BS_* codes)
//     ACT RD WR PR BST REF       level commands, at most one high, each held
//                                until bank_state shows its target state
//     resp_valid/resp_we         one-cycle pulse when the access starts
//     row_open/open_row          believed open row
//     ref_late                   interval expired with a refresh still pending
module bank_cmd_scheduler
    import ddr_pkg::*;
#(
    parameter int ROW_W  = 16,
    parameter int T_REFI = 7800,
    parameter int REFI_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [ROW_W-1:0] req_row,
    input  logic [4:0]       bank_state,
    output logic             ACT,
    output logic             RD,
    output logic             WR,
    output logic             PR,
    output logic             BST,
    output logic             REF,
    output logic             resp_valid,
    output logic             resp_we,
    output logic             row_open,
    output logic [ROW_W-1:0] open_row,
    output logic             ref_late
);

    sched_state_e     state, state_n;
    ret_e             ret, ret_n;
    logic             we_q, we_n;
    logic [ROW_W-1:0] row_q, row_n;
    logic             ref_pending, ref_pending_n;
    logic             row_open_n;
    logic [ROW_W-1:0] open_row_n;
    logic             resp_n, late_n, ref_clr;
    logic             expire;

    refresh_timer #(.T_REFI(T_REFI), .REFI_W(REFI_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .expire (expire)
    );

    always_comb begin
        state_n    = state;
        ret_n      = ret;
        we_n       = we_q;
        row_n      = row_q;
        row_open_n = row_open;
        open_row_n = open_row;
        resp_n     = 1'b0;
        ref_clr    = 1'b0;
        case (state)
            S_IDLE: begin
                // req_ready trails ref_pending by a cycle; refresh wins
                // here so a request shown in that cycle is not consumed.
                if (ref_pending) begin
                    if (row_open) begin
                        state_n = S_PRE;
                        ret_n   = RET_REF;
                    end else begin
                        state_n = S_REF;
                    end
                end else if (req_valid && req_ready) begin
                    we_n  = req_we;
                    row_n = req_row;
                    if (row_open && (req_row == open_row)) begin
                        state_n = S_RW;
                    end else if (row_open) begin
                        state_n = S_PRE;
                        ret_n   = RET_ACT;
                    end else begin
                        state_n = S_ACT;
                    end
                end
            end
            S_PRE:      if (bank_state == BS_PRECHARGING) state_n = S_PRE_WAIT;
            S_PRE_WAIT: if (bank_state == BS_IDLE) begin
                row_open_n = 1'b0;
                state_n    = (ret == RET_REF) ? S_REF : S_ACT;
            end
            S_ACT:      if (bank_state == BS_ACTIVATING) state_n = S_ACT_WAIT;
            S_ACT_WAIT: if (bank_state == BS_BANK_ACTIVE) begin
                row_open_n = 1'b1;
                open_row_n = row_q;
                state_n    = S_RW;
            end
            S_RW: if ((we_q && bank_state == BS_WRITING) ||
                      (!we_q && bank_state == BS_READING)) begin
                resp_n  = 1'b1;
                state_n = S_BST;
            end
            S_BST:      if (bank_state == BS_BANK_ACTIVE) state_n = S_IDLE;
            S_REF:      if (bank_state == BS_REFRESHING) begin
                ref_clr = 1'b1;
                state_n = S_REF_WAIT;
            end
            S_REF_WAIT: if (bank_state == BS_IDLE) state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase

        // Only one refresh is ever owed; a second expiry just reports late.
        ref_pending_n = expire | (ref_pending & ~ref_clr);
        late_n        = expire & ref_pending & ~ref_clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ret         <= RET_ACT;
            we_q        <= 1'b0;
            row_q       <= '0;
            ref_pending <= 1'b0;
            ref_late    <= 1'b0;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_we     <= 1'b0;
            row_open    <= 1'b0;
            open_row    <= '0;
            ACT         <= 1'b0;
            RD          <= 1'b0;
            WR          <= 1'b0;
            PR          <= 1'b0;
            BST         <= 1'b0;
            REF         <= 1'b0;
        end else begin
            state       <= state_n;
            ret         <= ret_n;
            we_q        <= we_n;
            row_q       <= row_n;
            ref_pending <= ref_pending_n;
            ref_late    <= late_n;
            row_open    <= row_open_n;
            open_row    <= open_row_n;
            resp_valid  <= resp_n;
            resp_we     <= resp_n & we_q;
            // Ready drops as soon as a request is taken, but only sees a
            // new refresh one cycle after ref_pending rises.
            req_ready   <= (state_n == S_IDLE) && !ref_pending;
            // Commands decode from the next state, so each drops on the
            // same edge that observes its target bank state.
            ACT         <= (state_n == S_ACT);
            PR          <= (state_n == S_PRE);
            REF         <= (state_n == S_REF);
            BST         <= (state_n == S_BST);
            RD          <= (state_n == S_RW) && !we_n;
            WR          <= (state_n == S_RW) &&  we_n;
        end
    end

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
module tb_bank_cmd_scheduler;
    import ddr_pkg::*;

    localparam int NU = 2;
    localparam int TREFI0 = 1000;
    localparam int TREFI1 = 64;
    localparam int T_RCD = 4, T_RP = 4, T_CL = 4, T_RFC = 20;
    localparam logic [2:0] C_ACT = 3'd1, C_PR = 3'd2, C_RD = 3'd3,
                           C_WR = 3'd4, C_BST = 3'd5, C_REF = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n[NU];
    logic        req_valid[NU], req_ready[NU], req_we[NU];
    logic [15:0] req_row[NU];
    logic [4:0]  bs[NU];
    logic        act[NU], rd[NU], wr[NU], pr[NU], bst[NU], rf[NU];
    logic        resp_valid[NU], resp_we[NU], row_open[NU], ref_late[NU];
    logic [15:0] open_row[NU];

    int tm[NU], cas[NU], cyc[NU];
    bit freeze[NU] = '{0, 0};

    int          multi[NU]  = '{0, 0};
    int          seqlen[NU] = '{0, 0};
    int          nresp[NU]  = '{0, 0};
    int          nlate[NU]  = '{0, 0};
    logic [63:0] seqlog[NU] = '{64'd0, 64'd0};
    logic [5:0]  last[NU]   = '{6'd0, 6'd0};

    bit          m_open[NU] = '{0, 0};
    logic [15:0] m_row[NU]  = '{16'd0, 16'd0};

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bank_cmd_scheduler #(.ROW_W(16), .T_REFI(TREFI0), .REFI_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_row(req_row[0]), .bank_state(bs[0]),
        .ACT(act[0]), .RD(rd[0]), .WR(wr[0]), .PR(pr[0]), .BST(bst[0]), .REF(rf[0]),
        .resp_valid(resp_valid[0]), .resp_we(resp_we[0]), .row_open(row_open[0]),
        .open_row(open_row[0]), .ref_late(ref_late[0]));

    bank_cmd_scheduler #(.ROW_W(16), .T_REFI(TREFI1), .REFI_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_row(req_row[1]), .bank_state(bs[1]),
        .ACT(act[1]), .RD(rd[1]), .WR(wr[1]), .PR(pr[1]), .BST(bst[1]), .REF(rf[1]),
        .resp_valid(resp_valid[1]), .resp_we(resp_we[1]), .row_open(row_open[1]),
        .open_row(open_row[1]), .ref_late(ref_late[1]));

    // Behavioural bank FSM: T_RCD/T_RP/T_CL/T_RFC; CAS gate closed for T_CL
    // cycles after each burst stop.
    always @(posedge clk) begin
        for (int i = 0; i < NU; i++) begin
            if (!rst_n[i]) begin
                bs[i] <= BS_IDLE; tm[i] <= 0; cas[i] <= 0; cyc[i] <= 0;
            end else begin
                cyc[i] <= cyc[i] + 1;
                if (!freeze[i]) begin
                    case (bs[i])
                        BS_IDLE:
                            if (act[i])     begin bs[i] <= BS_ACTIVATING; tm[i] <= T_RCD; end
                            else if (rf[i]) begin bs[i] <= BS_REFRESHING; tm[i] <= T_RFC; end
                        BS_ACTIVATING, BS_PRECHARGING, BS_REFRESHING:
                            if (tm[i] > 1) tm[i] <= tm[i] - 1;
                            else bs[i] <= (bs[i] == BS_ACTIVATING) ? BS_BANK_ACTIVE : BS_IDLE;
                        BS_BANK_ACTIVE: begin
                            if (cas[i] > 0) cas[i] <= cas[i] - 1;
                            if ((rd[i] || wr[i]) && cas[i] == 0) bs[i] <= rd[i] ? BS_READING : BS_WRITING;
                            else if (pr[i]) begin bs[i] <= BS_PRECHARGING; tm[i] <= T_RP; end
                        end
                        BS_READING, BS_WRITING:
                            if (bst[i]) begin bs[i] <= BS_BANK_ACTIVE; cas[i] <= T_CL; end
                        default: ;
                    endcase
                end
            end
        end
    end

    function automatic logic [5:0] cmdv(int i);
        return {act[i], pr[i], rd[i], wr[i], bst[i], rf[i]};
    endfunction

    function automatic logic [2:0] code(logic [5:0] v);
        if (v[5]) return C_ACT;
        if (v[4]) return C_PR;
        if (v[3]) return C_RD;
        if (v[2]) return C_WR;
        if (v[1]) return C_BST;
        return C_REF;
    endfunction

    function automatic logic [63:0] push(logic [63:0] s, logic [2:0] c);
        return {s[60:0], c};
    endfunction

    function automatic logic [26:0] outv(int u);
        return {req_ready[u], cmdv(u), resp_valid[u], resp_we[u], ref_late[u], row_open[u], open_row[u]};
    endfunction

    function automatic int cntv(int u);
        return (u == 0) ? int'(dut0.u_timer.cnt) : int'(dut1.u_timer.cnt);
    endfunction

    // Command-trace monitor: logs each newly raised command and counts pulses.
    always @(negedge clk) begin
        for (int i = 0; i < NU; i++) begin
            if ($countones(cmdv(i)) > 1) multi[i] <= multi[i] + 1;
            if (cmdv(i) != 6'd0 && cmdv(i) != last[i]) begin
                seqlog[i] <= push(seqlog[i], code(cmdv(i)));
                seqlen[i] <= seqlen[i] + 1;
            end
            last[i] <= cmdv(i);
            if (resp_valid[i]) nresp[i] <= nresp[i] + 1;
            if (ref_late[i])   nlate[i] <= nlate[i] + 1;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset(input int u);
        rst_n[u] = 1'b0; req_valid[u] = 1'b0;
        tick(); tick();
        vectors++;
        if (outv(u) !== 27'd0) begin
            miscompares++; $display("FAIL reset_outputs u%0d: got %h want 0", u, outv(u));
        end
        vectors++;
        if (cntv(u) != ((u == 0) ? TREFI0 : TREFI1)) begin
            miscompares++; $display("FAIL reset_counter u%0d: got %0d", u, cntv(u));
        end
        rst_n[u] = 1'b1;
        tick();
        vectors++;
        if (req_ready[u] !== 1'b1) begin
            miscompares++; $display("FAIL ready_after_reset u%0d: got %b want 1", u, req_ready[u]);
        end
        m_open[u] = 0;
    endtask

    // One request through the open-row policy, checked against the model.
    task automatic do_access(input int u, input logic we, input logic [15:0] row);
        int s_len, s_resp, s_multi, n, lat, c, exp_len;
        logic [63:0] exp_seq, mask;
        bit hit;
        s_len = seqlen[u]; s_resp = nresp[u]; s_multi = multi[u];
        hit = m_open[u] && (m_row[u] == row);
        exp_seq = 64'd0; exp_len = 0;
        if (!hit) begin
            if (m_open[u]) begin exp_seq = push(exp_seq, C_PR); exp_len++; end
            exp_seq = push(exp_seq, C_ACT); exp_len++;
        end
        exp_seq = push(exp_seq, we ? C_WR : C_RD); exp_len++;
        exp_seq = push(exp_seq, C_BST); exp_len++;
        mask = (64'd1 << (3 * exp_len)) - 64'd1;

        req_we[u] = we; req_row[u] = row; req_valid[u] = 1'b1;
        n = 0;
        while (!req_ready[u] && n < 200) begin tick(); n++; end
        tick();
        req_valid[u] = 1'b0;
        c = cas[u];
        lat = 0;
        while (!resp_valid[u] && lat < 200) begin tick(); lat++; end
        vectors++;
        if (resp_valid[u] !== 1'b1) begin
            miscompares++; $display("FAIL resp_timeout u%0d row %h: no resp_valid", u, row);
        end else begin
            vectors++;
            if (resp_we[u] !== we) begin
                miscompares++; $display("FAIL resp_we u%0d: got %b want %b", u, resp_we[u], we);
            end
            if (hit) begin
                vectors++;
                if (lat != 2 + c) begin
                    miscompares++; $display("FAIL hit_latency u%0d: got %0d want %0d", u, lat, 2 + c);
                end
            end
        end
        n = 0;
        while (!req_ready[u] && n < 200) begin tick(); n++; end
        m_open[u] = 1; m_row[u] = row;
        vectors++;
        if (row_open[u] !== 1'b1 || open_row[u] !== row) begin
            miscompares++;
            $display("FAIL open_row u%0d: got %b/%h want 1/%h", u, row_open[u], open_row[u], row);
        end
        vectors++;
        if (seqlen[u] - s_len != exp_len || (seqlog[u] & mask) !== exp_seq) begin
            miscompares++;
            $display("FAIL cmd_seq u%0d: got %h (%0d cmds) want %h (%0d cmds)",
                     u, seqlog[u] & mask, seqlen[u] - s_len, exp_seq, exp_len);
        end
        vectors++;
        if (multi[u] != s_multi || nresp[u] - s_resp != 1) begin
            miscompares++;
            $display("FAIL onehot_resp u%0d: overlaps %0d resp %0d want 0/1",
                     u, multi[u] - s_multi, nresp[u] - s_resp);
        end
    endtask

    task automatic test_cold_read();
        do_access(0, 1'b0, 16'h0012);
    endtask

    task automatic test_row_hit();
        repeat (10) tick();
        do_access(0, 1'b1, 16'h0012);
    endtask

    task automatic test_row_miss();
        do_access(0, 1'b0, 16'h0034);
    endtask

    task automatic test_back_to_back();
        do_access(0, 1'b1, 16'h0034);
        do_access(0, 1'b0, 16'h0034);
        do_access(0, 1'b1, 16'h8034);
    endtask

    task automatic test_random();
        logic [15:0] row;
        test_reset(0);
        for (int k = 0; k < 20; k++) begin
            case ($urandom_range(0, 3))
                0:       row = 16'h0012;
                1:       row = 16'h8012;
                2:       row = 16'h0034;
                default: row = 16'($urandom);
            endcase
            repeat ($urandom_range(0, 3)) tick();
            do_access(0, 1'($urandom_range(0, 1)), row);
        end
    endtask

    task automatic test_reset_mid_op();
        int s_resp, n;
        s_resp = nresp[0];
        req_we[0] = 1'b0; req_row[0] = 16'h0099; req_valid[0] = 1'b1;
        n = 0;
        while (!(rd[0] || wr[0]) && n < 200) begin tick(); n++; end
        freeze[0] = 1;
        req_valid[0] = 1'b0;
        #2 rst_n[0] = 1'b0;
        #1;
        vectors++;
        if (outv(0) !== 27'd0) begin
            miscompares++; $display("FAIL async_reset_outputs: got %h want 0", outv(0));
        end
        vectors++;
        if (cntv(0) != TREFI0) begin
            miscompares++; $display("FAIL async_reset_counter: got %0d want %0d", cntv(0), TREFI0);
        end
        tick(); tick();
        freeze[0] = 0;
        rst_n[0] = 1'b1;
        repeat (8) tick();
        m_open[0] = 0;
        vectors++;
        if (nresp[0] != s_resp) begin
            miscompares++; $display("FAIL resp_after_abort: got %0d pulses want 0", nresp[0] - s_resp);
        end
    endtask

    task automatic test_refresh();
        int s_len, s_resp, s_late, n;
        test_reset(1);
        do_access(1, 1'b0, 16'h0021);
        while (cyc[1] < TREFI1) tick();
        vectors++;
        if (req_ready[1] !== 1'b1 || cntv(1) != TREFI1) begin
            miscompares++;
            $display("FAIL ref_set_cycle: ready %b cnt %0d want 1/%0d", req_ready[1], cntv(1), TREFI1);
        end
        s_len = seqlen[1]; s_resp = nresp[1]; s_late = nlate[1];
        req_we[1] = 1'b0; req_row[1] = 16'h0056; req_valid[1] = 1'b1;
        tick();
        vectors++;
        if (req_ready[1] !== 1'b0) begin
            miscompares++; $display("FAIL ready_fall: got %b want 0", req_ready[1]);
        end
        n = 0;
        while (!req_ready[1] && n < 200) begin tick(); n++; end
        vectors++;
        if (req_ready[1] !== 1'b1 || row_open[1] !== 1'b0 || nresp[1] != s_resp) begin
            miscompares++;
            $display("FAIL after_refresh: ready %b row_open %b resp %0d want 1/0/0",
                     req_ready[1], row_open[1], nresp[1] - s_resp);
        end
        tick();
        req_valid[1] = 1'b0;
        n = 0;
        while (!resp_valid[1] && n < 200) begin tick(); n++; end
        n = 0;
        while (!req_ready[1] && n < 200) begin tick(); n++; end
        m_open[1] = 1; m_row[1] = 16'h0056;
        vectors++;
        if (seqlen[1] - s_len != 5 ||
            (seqlog[1] & 64'h7FFF) !== {49'd0, C_PR, C_REF, C_ACT, C_RD, C_BST}) begin
            miscompares++;
            $display("FAIL refresh_seq: got %h (%0d cmds) want PR,REF,ACT,RD,BST",
                     seqlog[1] & 64'h7FFF, seqlen[1] - s_len);
        end
        vectors++;
        if (nresp[1] - s_resp != 1 || nlate[1] != s_late || row_open[1] !== 1'b1 || open_row[1] !== 16'h0056) begin
            miscompares++;
            $display("FAIL refresh_access: resp %0d late %0d row %b/%h want 1/0/1/0056",
                     nresp[1] - s_resp, nlate[1] - s_late, row_open[1], open_row[1]);
        end
    endtask

    task automatic test_stall();
        int s_len, s_resp, s_late, n;
        test_reset(1);
        s_len = seqlen[1]; s_resp = nresp[1]; s_late = nlate[1];
        req_we[1] = 1'b0; req_row[1] = 16'h0077; req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        n = 0;
        while (bs[1] !== BS_ACTIVATING && n < 50) begin tick(); n++; end
        freeze[1] = 1;
        repeat (130) tick();
        freeze[1] = 0;
        n = 0;
        while (!resp_valid[1] && n < 200) begin tick(); n++; end
        n = 0;
        while (!req_ready[1] && n < 200) begin tick(); n++; end
        vectors++;
        if (nlate[1] - s_late != 1) begin
            miscompares++; $display("FAIL ref_late_count: got %0d want 1", nlate[1] - s_late);
        end
        vectors++;
        if (seqlen[1] - s_len != 5 ||
            (seqlog[1] & 64'h7FFF) !== {49'd0, C_ACT, C_RD, C_BST, C_PR, C_REF}) begin
            miscompares++;
            $display("FAIL stall_seq: got %h (%0d cmds) want ACT,RD,BST,PR,REF",
                     seqlog[1] & 64'h7FFF, seqlen[1] - s_len);
        end
        vectors++;
        if (nresp[1] - s_resp != 1 || row_open[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_done: resp %0d row_open %b want 1/0", nresp[1] - s_resp, row_open[1]);
        end
        while (cyc[1] < 3 * TREFI1 + 8) tick();
        vectors++;
        if (nlate[1] - s_late != 1) begin
            miscompares++; $display("FAIL ref_late_after: got %0d want 1", nlate[1] - s_late);
        end
        m_open[1] = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NU; i++) begin
            rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_row[i] = 16'd0;
        end
        tick();
        test_reset(0);
        test_reset(1);
        test_cold_read();
        test_row_hit();
        test_row_miss();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        test_refresh();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
